// File: rtl/or3_sweep_tester.sv
// Built-in self-test driver for a 3-input OR gate: sweeps all eight input
// vectors, captures the gate's response to each and reports a verdict.
module or3_sweep_tester #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dout,
  output logic       din_a,
  output logic       din_b,
  output logic       din_c,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       pass,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] EXPECTED = 8'hFE;
  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       pass_q, pass_d;
  logic [2:0] fail_idx_q, fail_idx_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] capture_tbl;
  logic [7:0] mismatch;
  logic [2:0] first_bad;

  // Table as it would look if the current vector's response were captured now.
  always_comb begin
    capture_tbl         = result_q;
    capture_tbl[idx_q]  = dout;
    mismatch            = capture_tbl ^ EXPECTED;
  end

  always_comb begin
    first_bad = '0;
    for (int k = 7; k >= 0; k--) begin
      if (mismatch[k]) first_bad = 3'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          result_d   = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          result_d = capture_tbl;
          cnt_d    = '0;
          if (idx_q == 3'd7) begin
            state_d    = DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            vec_d      = '0;
            pass_d     = (capture_tbl == EXPECTED);
            fail_idx_d = first_bad;
          end else begin
            idx_d = idx_q + 3'd1;
            vec_d = idx_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign {din_a, din_b, din_c} = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_or3_sweep_tester.sv
// Directed bench for or3_sweep_tester: good and faulty gate models, short
// dwell, held start and mid-sweep reset.
module tb_or3_sweep_tester;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic       dout4, dout1;
  logic       a4, b4, c4, busy4, done4, pass4;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] result4, result1;
  logic [2:0] fail4, fail1;
  int         gate_mode;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         mode;
    logic [7:0] exp_result;
    logic       exp_pass;
    logic [2:0] exp_fail;
    string      name;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  // Gate models: 0 good OR3, 1 stuck-at-1, 2 missing c term, 3 stuck-at-0, 4 a only
  always_comb begin
    case (gate_mode)
      1:       dout4 = 1'b1;
      2:       dout4 = a4 | b4;
      3:       dout4 = 1'b0;
      4:       dout4 = a4;
      default: dout4 = a4 | b4 | c4;
    endcase
  end

  assign dout1 = a1 | b1 | c1;

  or3_sweep_tester #(.DWELL(DW)) dut4 (
    .clk(clk), .rst(rst), .start(start), .dout(dout4),
    .din_a(a4), .din_b(b4), .din_c(c4), .busy(busy4), .done(done4),
    .result(result4), .pass(pass4), .fail_idx(fail4)
  );

  or3_sweep_tester #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dout(dout1),
    .din_a(a1), .din_b(b1), .din_c(c1), .busy(busy1), .done(done1),
    .result(result1), .pass(pass1), .fail_idx(fail1)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] status4();
    return {3'b000, busy4, done4, a4, b4, c4};
  endfunction

  function automatic logic [7:0] status1();
    return {3'b000, busy1, done1, a1, b1, c1};
  endfunction

  // One full sweep on the DWELL=4 instance with per-cycle sequence checks.
  task automatic applyStimulus(input int mode_in, input logic [7:0] exp_res, input logic exp_pass,
                               input logic [2:0] exp_fail, input string tag);
    gate_mode = mode_in;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 8 * DW; n++) begin
      checkOutput($sformatf("%s status c%0d", tag, n), status4(), {3'b000, 1'b1, 1'b0, 3'((n - 1) / DW)});
      @(negedge clk);
    end
    checkOutput($sformatf("%s done status", tag), status4(), 8'b0000_1000);
    checkOutput($sformatf("%s result", tag), result4, exp_res);
    checkOutput($sformatf("%s pass", tag), {7'd0, pass4}, {7'd0, exp_pass});
    checkOutput($sformatf("%s fail_idx", tag), {5'd0, fail4}, {5'd0, exp_fail});
    @(negedge clk);
    checkOutput($sformatf("%s idle after done", tag), status4(), 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int done_seen;
    tbl[0] = '{0, 8'hFE, 1'b1, 3'd0, "good"};
    tbl[1] = '{1, 8'hFF, 1'b0, 3'd0, "stuck1"};
    tbl[2] = '{2, 8'hFC, 1'b0, 3'd1, "no_c"};
    tbl[3] = '{3, 8'h00, 1'b0, 3'd1, "stuck0"};
    tbl[4] = '{4, 8'hF0, 1'b0, 3'd1, "a_only"};

    gate_mode = 0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset status", status4(), 8'h00);
    checkOutput("reset result", result4, 8'h00);
    checkOutput("reset pass/fail", {4'd0, pass4, fail4}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      applyStimulus(tbl[i].mode, tbl[i].exp_result, tbl[i].exp_pass, tbl[i].exp_fail, tbl[i].name);

    // DWELL=1: new vector each cycle, done in cycle 9
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      checkOutput($sformatf("dw1 status c%0d", n), status1(), {3'b000, 1'b1, 1'b0, 3'(n - 1)});
      @(negedge clk);
    end
    checkOutput("dw1 done status", status1(), 8'b0000_1000);
    checkOutput("dw1 result", result1, 8'hFE);
    checkOutput("dw1 pass", {7'd0, pass1}, 8'd1);

    // start held high across the sweep and the DONE cycle
    gate_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int n = 1; n < 8 * DW + 1; n++) @(negedge clk);
    checkOutput("held done status", status4(), 8'b0000_1000);
    @(negedge clk);
    checkOutput("held idle after done", status4(), 8'h00);
    @(negedge clk) start = 1'b0;
    checkOutput("held second sweep starts", status4(), 8'b0001_0000);
    repeat (8 * DW) @(negedge clk);
    checkOutput("held second done", status4(), 8'b0000_1000);
    checkOutput("held second result", result4, 8'hFE);
    @(negedge clk);

    // reset and start together: reset wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst+start status", status4(), 8'h00);

    // reset while vector 3 is driven
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (13) @(negedge clk);
    checkOutput("pre-abort vector3", status4(), 8'b0001_0011);
    checkOutput("pre-abort partial result", result4, 8'h06);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checkOutput("abort status", status4(), 8'h00);
    checkOutput("abort result", result4, 8'h00);
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done4) done_seen++;
      @(negedge clk);
    end
    checkOutput("abort no done", 8'(done_seen), 8'd0);
    applyStimulus(0, 8'hFE, 1'b1, 3'd0, "post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/or3_sweep_tester.md
# or3_sweep_tester

Stimulus-and-check stage wrapped around the 3-input OR gate. It drives `din_a`/`din_b`/`din_c` through all eight input combinations, holds each for a programmable number of clock cycles and samples the gate's `dout` at the end of each hold. It then reports the captured 8-entry truth table and a pass/fail verdict. It sits directly upstream of the gate and consumes the gate's output, so it can be used as an on-chip self-test in place of a hand-written stimulus sequence.

## Interface
- `DWELL`, default 4: clock cycles each input vector is held; legal range 1–255.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a sweep; sampled only in IDLE.
- `dout`  input  1  output of the OR gate under test (combinational from `din_*`).
- `din_a`  output  1  gate input, bit 2 of the vector index.
- `din_b`  output  1  gate input, bit 1 of the vector index.
- `din_c`  output  1  gate input, bit 0 of the vector index.
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `result`  output  8  captured truth table; `result[k]` = `dout` observed for vector k.
- `pass`  output  1  `result == 8'hFE`; valid from `done` until the next start.
- `fail_idx`  output  3  lowest vector index whose captured bit mismatches the expected value; 0 if none.

## Operation
- Expected response for vector k = `{din_a,din_b,din_c}`: 0 when k = 0, otherwise 1. The expected table is `8'hFE`.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - `din_*` = 0 and `busy` = 0.
  - `start` = 1 causes the following updates at the next edge:
    - clear `result`, `pass` and `fail_idx`;
    - set vector index to 0 and dwell counter to 0;
    - go to DRIVE.
- DRIVE:
  - `{din_a,din_b,din_c}` = vector index (registered outputs) and `busy` = 1.
  - The dwell counter increments every cycle.
  - When the counter equals `DWELL-1`, the following happen at that edge:
    - `result[index]` ← `dout`;
    - the counter resets to 0;
    - if index = 7, go to DONE; otherwise increment the index.
- DONE:
  - Lasts exactly one cycle, with `done` = 1, `busy` = 0 and `din_*` = 0.
  - `pass` and `fail_idx` are already valid in this cycle.
  - Return to IDLE.
- `pass` and `fail_idx` are computed from the full captured `result` and registered on entry to DONE. They hold until the next accepted start or reset.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- The index is 3 bits and must not wrap past 7; the transition to DONE is taken at index 7.
- The dwell counter is 8 bits. `DWELL` = 1 means one cycle per vector, and the sample is taken at the edge ending that cycle.

## Timing
- Reset values:
  - `din_a`, `din_b`, `din_c`, `busy`, `done`, `pass` = 0;
  - `result` = 8'h00, `fail_idx` = 0;
  - state = IDLE.
- Reset asserted mid-sweep aborts at the next edge: all outputs return to their reset values and no `done` pulse is produced.
- Let `start` be sampled high at edge E0. Then:
  - `busy` rises and vector 0 appears in the cycle after E0;
  - vector k is held for cycles k·DWELL+1 through (k+1)·DWELL counted from E0;
  - `dout` is sampled at edge E(k+1)·DWELL;
  - DONE, with `done` = 1, occupies the cycle after E8·DWELL.
- Latency from `start` to `done` is 8·DWELL+1 cycles. For the default `DWELL` = 4, `done` is high in cycle 33.
- Back-to-back sweeps: `start` high during the DONE cycle is ignored. `start` high in the following IDLE cycle is accepted.
- `rst` and `start` asserted in the same cycle: reset wins.

## Test plan
- Reset, then `start` pulse with a good OR gate and `DWELL` = 4 → the `din` sequence is 000, 001, …, 111, each held 4 cycles; `done` is high at cycle 33; `result` = 8'hFE, `pass` = 1, `fail_idx` = 0.
- `dout` tied to 1 (stuck-at-1) → `result` = 8'hFF, `pass` = 0, `fail_idx` = 0.
- `dout` = `din_a | din_b` (missing `din_c` term) → `result` = 8'hFC, `pass` = 0, `fail_idx` = 1.
- `DWELL` = 1 with a good gate → a new vector every cycle; `done` at cycle 9 after start; `result` = 8'hFE.
- `start` held high throughout the sweep and into DONE → exactly one sweep; a second sweep begins only from the IDLE cycle after DONE.
- `rst` pulsed while vector 3 is driven → the next cycle shows `din_*` = 0, `busy` = 0, `result` = 0 and no `done`; a subsequent `start` gives a full, correct sweep.
